// File: rtl/mul_ctrl_pkg.sv
// Shared encodings for the iterative multiply/accumulate controller.
// Macro MUL_RADIX4_EN selects two multiplier bits per step instead of one.
package mul_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_ACC  = 2'b10,
    ST_DONE = 2'b11
  } mul_state_t;

  localparam logic MulStart          = 1'b1;
  localparam logic MulStop           = 1'b0;
  localparam logic MulResultReady    = 1'b1;
  localparam logic MulResultNotReady = 1'b0;

  localparam logic [1:0] MulAccNone = 2'b00;
  localparam logic [1:0] MulAccAdd  = 2'b01;
  localparam logic [1:0] MulAccSub  = 2'b10;

`ifdef MUL_RADIX4_EN
  localparam int unsigned BitsPerStep = 2;
`else
  localparam int unsigned BitsPerStep = 1;
`endif
  localparam int unsigned StepCount = 32 / BitsPerStep;
  localparam logic [5:0]  LastStep  = 6'(StepCount - 1);

  // Unsigned magnitude; 0x80000000 maps to 2^31, which still fits in 32 bits.
  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mul_step.sv
// One combinational shift-add step of the multiplier.
// With MUL_RADIX4_EN two multiplier bits are retired per step, otherwise one.
module mul_step (
  input  logic [63:0] acc,
  input  logic [63:0] mcand,
  input  logic [31:0] mplier,
  output logic [63:0] acc_next,
  output logic [63:0] mcand_next,
  output logic [31:0] mplier_next
);

  always_comb begin
    acc_next = acc;
`ifdef MUL_RADIX4_EN
    if (mplier[0]) acc_next = acc_next + mcand;
    if (mplier[1]) acc_next = acc_next + {mcand[62:0], 1'b0};
    mcand_next  = {mcand[61:0], 2'b00};
    mplier_next = {2'b00, mplier[31:2]};
`else
    if (mplier[0]) acc_next = acc_next + mcand;
    mcand_next  = {mcand[62:0], 1'b0};
    mplier_next = {1'b0, mplier[31:1]};
`endif
  end

endmodule

// File: rtl/mul_ctrl.sv
// Iterative multiplier with optional HI/LO accumulate for the EX stage.
// Radix is chosen by MUL_RADIX4_EN (see mul_step); results are identical either way.
module mul_ctrl
  import mul_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        annul_i,
  input  logic        signed_mul_i,
  input  logic [1:0]  acc_op_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic [63:0] hilo_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        stallreq_o,
  output mul_state_t  dbg_state
);

  // Handshake: start_i is held high until ready_o is seen; ready_o stays high
  // with result_o stable until start_i drops; annul_i cancels at any point.

  mul_state_t  state_q, state_d;
  logic [63:0] acc_q, mcand_q, result_q;
  logic [31:0] mplier_q;
  logic [5:0]  cnt_q;
  logic        sign_q;
  logic [1:0]  acc_op_q;

  logic [63:0] step_acc, step_mcand;
  logic [31:0] step_mplier;
  logic [63:0] product, acc_result;
  logic        go, zero_op;

  assign go      = (start_i == MulStart) && !annul_i;
  assign zero_op = (opdata1_i == 32'd0) || (opdata2_i == 32'd0);

  mul_step u_step (
    .acc         (acc_q),
    .mcand       (mcand_q),
    .mplier      (mplier_q),
    .acc_next    (step_acc),
    .mcand_next  (step_mcand),
    .mplier_next (step_mplier)
  );

  always_comb begin
    product    = sign_q ? (~acc_q + 64'd1) : acc_q;
    acc_result = product;
    case (acc_op_q)
      MulAccAdd: acc_result = hilo_i + product;
      MulAccSub: acc_result = hilo_i - product;
      default:   acc_result = product;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (go) state_d = zero_op ? ST_ACC : ST_MUL;
      ST_MUL: begin
        if (!go)                    state_d = ST_IDLE;
        else if (cnt_q == LastStep) state_d = ST_ACC;
      end
      ST_ACC:  state_d = go ? ST_DONE : ST_IDLE;
      ST_DONE: if (!go) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath updates unconditionally per state; an abort simply leaves stale
  // values that the next start overwrites and that never reach result_o.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      acc_op_q <= MulAccNone;
      result_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (go) begin
          mcand_q  <= {32'd0, magnitude(opdata1_i, signed_mul_i)};
          mplier_q <= magnitude(opdata2_i, signed_mul_i);
          sign_q   <= signed_mul_i & (opdata1_i[31] ^ opdata2_i[31]);
          acc_op_q <= acc_op_i;
          acc_q    <= '0;
          cnt_q    <= '0;
        end
        ST_MUL: begin
          acc_q    <= step_acc;
          mcand_q  <= step_mcand;
          mplier_q <= step_mplier;
          cnt_q    <= cnt_q + 6'd1;
        end
        ST_ACC:  result_q <= acc_result;
        default: ;
      endcase
    end
  end

  assign ready_o    = (state_q == ST_DONE) ? MulResultReady : MulResultNotReady;
  assign result_o   = (state_q == ST_DONE) ? result_q : 64'd0;
  assign stallreq_o = start_i & ~annul_i & (state_q != ST_DONE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mul_ctrl.sv
// Self-checking bench for mul_ctrl: directed cases, aborts, reset and random ops.
module tb_mul_ctrl;
  import mul_ctrl_pkg::*;

`ifdef MUL_RADIX4_EN
  localparam int Lat = 18;
`else
  localparam int Lat = 34;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic        signed_mul_i = 1'b0;
  logic [1:0]  acc_op_i = 2'b00;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic [63:0] hilo_i = '0;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;
  mul_state_t  dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  mul_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .signed_mul_i (signed_mul_i),
    .acc_op_i     (acc_op_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .hilo_i       (hilo_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .stallreq_o   (stallreq_o),
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "global timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn, input logic [1:0] op,
                                        input logic [63:0] hilo);
    logic [63:0] x, y, p;
    x = sgn ? {{32{a[31]}}, a} : {32'd0, a};
    y = sgn ? {{32{b[31]}}, b} : {32'd0, b};
    p = x * y;
    case (op)
      2'b01:   return hilo + p;
      2'b10:   return hilo - p;
      default: return p;
    endcase
  endfunction

  // Waits for ready_o counting edges, compares latency and the popped result,
  // then checks the hold cycle and the return to idle.
  task automatic wait_result(input int lat);
    int cyc;
    logic [63:0] e;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!ready_o && cyc < 100);
    check("latency", 64'(cyc), 64'(lat));
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
    check("result", result_o, e);
    check("stall_in_done", {63'd0, stallreq_o}, 64'd0);
    @(posedge clk); #1;
    check("hold_result", result_o, e);
    check("hold_ready", {63'd0, ready_o}, 64'd1);
    start_i = 1'b0;
    @(posedge clk); #1;
    check("idle_ready", {63'd0, ready_o}, 64'd0);
    check("idle_result", result_o, 64'd0);
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                       input logic [1:0] op, input logic [63:0] hilo);
    opdata1_i    = a;
    opdata2_i    = b;
    signed_mul_i = sgn;
    acc_op_i     = op;
    hilo_i       = hilo;
    start_i      = 1'b1;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input logic [1:0] op, input logic [63:0] hilo);
    drive(a, b, sgn, op, hilo);
    exp_q.push_back(model(a, b, sgn, op, hilo));
    #1;
    check("stall_at_start", {63'd0, stallreq_o}, 64'd1);
    wait_result((a == 0 || b == 0) ? 2 : Lat);
  endtask

  task automatic expect_no_ready(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (ready_o) seen++;
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    #12;
    check("reset_ready", {63'd0, ready_o}, 64'd0);
    check("reset_result", result_o, 64'd0);
    check("reset_state", {62'd0, dbg_state}, {62'd0, ST_IDLE});
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    run_op(32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 2'b00, 64'd0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 2'b00, 64'd0);
    run_op(32'd3, 32'd5, 1'b1, 2'b10, 64'h0000_0000_0000_0064);
    run_op(32'h1234_5678, 32'd0, 1'b0, 2'b01, 64'h0000_0001_0000_0000);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 2'b01, 64'h0123_4567_89AB_CDEF);
    run_op(32'hFFFF_FFF9, 32'd6, 1'b1, 2'b11, 64'hDEAD_BEEF_0000_0000);
    run_op(32'd0, 32'h8000_0001, 1'b1, 2'b10, 64'h0000_0000_0000_0010);

    // Annul mid-MUL with start held: back to idle, then a fresh full-latency op.
    drive(32'd7, 32'd9, 1'b0, 2'b00, 64'd0);
    repeat (10) @(posedge clk);
    #1;
    annul_i = 1'b1;
    #1;
    check("stall_annul", {63'd0, stallreq_o}, 64'd0);
    @(posedge clk); #1;
    check("annul_ready", {63'd0, ready_o}, 64'd0);
    check("annul_result", result_o, 64'd0);
    check("annul_state", {62'd0, dbg_state}, {62'd0, ST_IDLE});
    annul_i = 1'b0;
    exp_q.push_back(model(32'd7, 32'd9, 1'b0, 2'b00, 64'd0));
    wait_result(Lat);

    // Start dropped mid-MUL aborts silently.
    drive(32'd11, 32'd13, 1'b0, 2'b00, 64'd0);
    repeat (5) @(posedge clk);
    #1;
    start_i = 1'b0;
    expect_no_ready("drop_no_ready", Lat + 5);

    // Asynchronous reset mid-MUL discards the operation.
    drive(32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 2'b00, 64'd0);
    repeat (Lat - 14) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_mid_ready", {63'd0, ready_o}, 64'd0);
    check("rst_mid_result", result_o, 64'd0);
    check("rst_mid_state", {62'd0, dbg_state}, {62'd0, ST_IDLE});
    check("rst_mid_stall", {63'd0, stallreq_o}, 64'd1);
    start_i = 1'b0;
    #2;
    rst = 1'b1;
    expect_no_ready("rst_no_ready", Lat + 5);

    for (int i = 0; i < 8; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = (i % 3 == 2) ? 32'd0 : $urandom;
      run_op(a, b, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             {$urandom, $urandom});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
